// File: rtl/wb_regfile.sv
// Writeback-stage register file: commits MEM/WB results into 2**ADDR_W entries,
// serves two bypassed combinational read ports, counts retirements and emits a commit trace.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_hold,
    input  logic [DATA_W-1:0] wb_pc,
    input  logic [ADDR_W-1:0] wb_wa,
    input  logic [DATA_W-1:0] wb_wd,
    input  logic [DATA_W-1:0] wb_instr,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic              trace_valid,
    output logic [DATA_W-1:0] trace_pc,
    output logic [ADDR_W-1:0] trace_wa,
    output logic [DATA_W-1:0] trace_wd
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic              commit;
    logic              we;

    // A held WB stage keeps presenting the same instruction; it must commit only once,
    // on the first cycle the hold is released. A zero instruction word is a bubble.
    assign commit = !reset && !wb_hold && (wb_instr != '0);
    assign we     = commit && (wb_wa != '0);

    always_comb begin
        rd1 = regs[ra1];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (we && (ra1 == wb_wa)) begin
            rd1 = wb_wd;
        end
    end

    always_comb begin
        rd2 = regs[ra2];
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (we && (ra2 == wb_wa)) begin
            rd2 = wb_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wb_wa] <= wb_wd;
        end
    end

    // Trace fields only change on a commit so a debugger still sees the last one after the pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt  <= '0;
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_wa    <= '0;
            trace_wd    <= '0;
        end else begin
            trace_valid <= commit;
            if (commit) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
                trace_pc   <= wb_pc;
                trace_wa   <= we ? wb_wa : '0;
                trace_wd   <= we ? wb_wd : '0;
            end
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios then random traffic against an array model,
// with trace records checked through an expected queue by a separate monitor.
module tb_wb_regfile;
    logic        clk;
    logic        reset;
    logic        wb_hold;
    logic [31:0] wb_pc;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic [31:0] wb_instr;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] retire_cnt;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [4:0]  trace_wa;
    logic [31:0] trace_wd;

    wb_regfile dut (
        .clk(clk), .reset(reset), .wb_hold(wb_hold), .wb_pc(wb_pc), .wb_wa(wb_wa),
        .wb_wd(wb_wd), .wb_instr(wb_instr), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .retire_cnt(retire_cnt), .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_wa(trace_wa), .trace_wd(trace_wd)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model and scoreboard state
    logic [31:0] m_regs [32];
    logic [31:0] exp_cnt;
    logic        exp_tv;
    logic [68:0] last_trace;
    logic [68:0] exp_q [$];
    logic        mon_en;
    int          n_checks;
    int          n_fail;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic w,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (w && a == wa) return wd;
        return m_regs[a];
    endfunction

    // driver: one cycle of stimulus; read ports checked mid-cycle, model advanced at the edge
    task automatic step(input logic r, input logic h, input logic [31:0] pc, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [31:0] instr,
                        input logic [4:0] a1, input logic [4:0] a2);
        logic c;
        logic w;
        reset = r; wb_hold = h; wb_pc = pc; wb_wa = wa; wb_wd = wd; wb_instr = instr;
        ra1 = a1; ra2 = a2;
        @(negedge clk);
        c = !r && !h && (instr != 32'd0);
        w = c && (wa != 5'd0);
        if (mon_en) begin
            check("rd1", 96'(rd1), 96'(model_read(a1, w, wa, wd)));
            check("rd2", 96'(rd2), 96'(model_read(a2, w, wa, wd)));
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            exp_cnt = 32'd0;
            exp_tv = 1'b0;
            last_trace = '0;
            exp_q.delete();
        end else begin
            exp_tv = c;
            if (c) begin
                exp_cnt = exp_cnt + 32'd1;
                exp_q.push_back({pc, (w ? wa : 5'd0), (w ? wd : 32'd0)});
            end
            if (w) m_regs[wa] = wd;
        end
        #1;
    endtask

    // monitor: compares the registered outputs against the model after each edge
    always @(negedge clk) begin
        if (mon_en) begin
            check("retire_cnt", 96'(retire_cnt), 96'(exp_cnt));
            check("trace_valid", 96'(trace_valid), 96'(exp_tv));
            if (trace_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL trace_unexpected: got pc %0h expected no trace at %0t", trace_pc, $time);
                end else begin
                    logic [68:0] e;
                    e = exp_q.pop_front();
                    check("trace", 96'({trace_pc, trace_wa, trace_wd}), 96'(e));
                    last_trace = e;
                end
            end else begin
                check("trace_hold", 96'({trace_pc, trace_wa, trace_wd}), 96'(last_trace));
            end
        end
    end

    initial begin
        n_checks = 0; n_fail = 0; mon_en = 1'b0;
        exp_cnt = '0; exp_tv = 1'b0; last_trace = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        reset = 1'b1; wb_hold = 1'b0; wb_pc = '0; wb_wa = '0; wb_wd = '0; wb_instr = '0;
        ra1 = '0; ra2 = '0;
        @(posedge clk); #1;

        // reset then read
        step(1'b1, 1'b0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd31);
        mon_en = 1'b1;
        step(1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd31);

        // basic write with same-cycle bypass, then array read
        step(1'b0, 1'b0, 32'h3000, 5'd8, 32'h5, 32'h2408_0005, 5'd8, 5'd8);
        step(1'b0, 1'b0, 32'h3004, 5'd8, 32'h77, 32'h0, 5'd8, 5'd0);

        // write to register 0 is discarded but still retires
        step(1'b0, 1'b0, 32'h3008, 5'd0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, 5'd0);
        step(1'b0, 1'b0, 32'h300C, 5'd0, 32'h0, 32'h0, 5'd0, 5'd8);

        // hold: held instruction commits once on release
        step(1'b0, 1'b0, 32'h3010, 5'd9, 32'h11, 32'h1111_0000, 5'd1, 5'd9);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h3014, 5'd9, 32'h7, 32'hAAAA_0001, 5'd9, 5'd9);
        step(1'b0, 1'b0, 32'h3014, 5'd9, 32'h7, 32'hAAAA_0001, 5'd9, 5'd9);
        step(1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd8);

        // back-to-back same destination, bubble, then another write
        step(1'b0, 1'b0, 32'h4000, 5'd3, 32'h1, 32'h0000_0A01, 5'd3, 5'd4);
        step(1'b0, 1'b0, 32'h4004, 5'd3, 32'h2, 32'h0000_0A02, 5'd3, 5'd4);
        step(1'b0, 1'b0, 32'h4008, 5'd3, 32'h3, 32'h0, 5'd3, 5'd4);
        step(1'b0, 1'b0, 32'h400C, 5'd4, 32'h9, 32'h0000_0B01, 5'd3, 5'd4);
        step(1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd4);

        // reset in the same cycle as a commit drops it
        step(1'b1, 1'b0, 32'h5000, 5'd6, 32'h55, 32'h0000_0C01, 5'd6, 5'd3);
        step(1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd6, 5'd3);

        // random traffic; reads biased toward the destination to exercise the bypass
        for (int n = 0; n < 600; n++) begin
            logic        r;
            logic        h;
            logic [4:0]  wa;
            logic [4:0]  a1;
            logic [4:0]  a2;
            logic [31:0] instr;
            r = ($urandom_range(0, 99) < 2);
            h = ($urandom_range(0, 99) < 20);
            wa = 5'($urandom_range(0, 31));
            instr = ($urandom_range(0, 99) < 25) ? 32'd0 : ($urandom | 32'd1);
            a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            step(r, h, $urandom, wa, $urandom, instr, a1, a2);
        end

        step(1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        check("trace_queue_drained", 96'(exp_q.size()), 96'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register. Takes the WB-stage PC, write address, write data and instruction, and commits them into the 32-entry general register file.
- Supplies two bypassed read ports to the ID stage.
- Keeps a retired-instruction counter and a one-cycle-delayed commit trace for debug and verification.
- Sits directly after the MEM/WB register and consumes the same hold (stall) signal that freezes that register.

Parameters:
- DATA_W, 32, width of register data, PC and instruction.
- ADDR_W, 5, register address width (2**ADDR_W entries).
- CNT_W, 32, width of the retire counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wb_hold  input  1  same signal as the MEM/WB enable; 1 = pipeline frozen, WB inputs held.
- wb_pc  input  DATA_W  PC of the instruction in WB.
- wb_wa  input  ADDR_W  destination register; 0 = no write.
- wb_wd  input  DATA_W  writeback data.
- wb_instr  input  DATA_W  instruction word; 32'h0 = bubble/nop.
- ra1  input  ADDR_W  read address, port 1.
- ra2  input  ADDR_W  read address, port 2.
- rd1  output  DATA_W  read data, port 1 (combinational).
- rd2  output  DATA_W  read data, port 2 (combinational).
- retire_cnt  output  CNT_W  count of committed non-bubble instructions.
- trace_valid  output  1  pulses 1 cycle after a commit.
- trace_pc  output  DATA_W  PC of the traced commit.
- trace_wa  output  ADDR_W  effective destination of the traced commit (0 if no write).
- trace_wd  output  DATA_W  written data of the traced commit (0 if no write).

Behaviour:
- Reset is synchronous, active-high, on clk.
  - All 2**ADDR_W register entries are cleared to 0.
  - retire_cnt, trace_valid, trace_pc, trace_wa and trace_wd are cleared to 0.
  - Reset has priority over every other event in the same cycle, including a pending commit.
- commit = !reset && !wb_hold && (wb_instr != 0). Evaluated every cycle.
- Write enable: we = commit && (wb_wa != 0). On the clk edge with we=1, reg[wb_wa] <= wb_wd. Write latency is one edge.
- Register 0 is never written and always reads 0.
- Hold: while wb_hold=1 there is no write, no count and no trace, even though the WB inputs remain valid. On release, the held instruction commits exactly once.
- Read ports are combinational with a bypass:
  - rdN = 0 if raN == 0.
  - else rdN = wb_wd if we && (raN == wb_wa).
  - else rdN = reg[raN].
  - Both ports may bypass in the same cycle. Same-cycle write/read therefore returns the new value with zero-cycle latency.
- retire_cnt increments by 1 on each commit, including commits with wb_wa == 0. It wraps modulo 2**CNT_W with no saturation.
- Trace:
  - On the edge at which commit=1: trace_valid <= 1, trace_pc <= wb_pc, trace_wa <= (we ? wb_wa : 0), trace_wd <= (we ? wb_wd : 0).
  - On any edge with commit=0: trace_valid <= 0, and the other trace outputs hold their last values.
- Back-to-back commits produce one trace_valid pulse per cycle with no gaps.
- Two consecutive instructions writing the same register: the later one wins. A read during the second commit returns the second value through the bypass.
- Reset asserted mid-stream: the commit in that cycle is dropped, the counter is not incremented, and trace_valid is 0 after the edge.

Test Plan:
- Reset then read: assert reset 1 cycle, set ra1=5, ra2=31 -> rd1=0, rd2=0, retire_cnt=0, trace_valid=0.
- Basic write and bypass:
  - wb_instr=32'h2408_0005, wb_wa=8, wb_wd=32'h5, wb_pc=32'h3000, ra1=8 -> rd1=5 in the same cycle (bypass).
  - Next cycle, with wb_instr=0 -> rd1=5 from the array, trace_valid=1, trace_pc=32'h3000, trace_wa=8, trace_wd=5, retire_cnt=1.
- Register 0 write: wb_wa=0, wb_wd=32'hDEAD_BEEF, instr nonzero, ra1=0 -> rd1=0. Next cycle trace_wa=0, trace_wd=0, retire_cnt incremented.
- Hold: wb_hold=1 for 3 cycles with wb_wa=9, wb_wd=7, instr nonzero -> reg9 unchanged, ra2=9 reads the old value, retire_cnt unchanged, trace_valid=0. Release hold for 1 cycle -> reg9=7, retire_cnt +1, exactly one trace_valid pulse.
- Bubbles and back-to-back:
  - Sequence instr A (wa=3, wd=1), A' (wa=3, wd=2), 0, B (wa=4, wd=9) on consecutive cycles.
  - Required: reg3=2, reg4=9; trace_valid pattern 1,1,0,1; retire_cnt +3.
- Reset mid-operation: reset=1 in the same cycle as a commit with wa=6, wd=32'h55 -> reg6=0, retire_cnt=0, trace_valid=0 after the edge.
